// File: rtl/pipe_ctrl_chain.sv
// Control-word pipeline: STAGES latches after decode with per-stage stall/flush,
// bubble insertion, retire counting and sticky halt. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl_chain #(
   parameter int             STAGES    = 3,
   parameter int             CW        = 16,
   parameter int             CNT_W     = 16,
   parameter int             HALT_BIT  = 0,
   parameter logic [CW-1:0]  BUBBLE_CW = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [CW-1:0]          ctrl_in,
   input  logic                   valid_in,
   input  logic [STAGES-1:0]      write_en,
   input  logic [STAGES-1:0]      flush,
   output logic [STAGES*CW-1:0]   ctrl_stage,
   output logic [STAGES-1:0]      valid_stage,
   output logic                   retire,
   output logic [CNT_W-1:0]       num_inst,
`ifdef PIPE_CTRL_PERF_EN
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       bubble_cnt,
`endif
   output logic                   is_halted
);

   logic [STAGES-1:0][CW-1:0] ctrl_q, ctrl_d;
   logic [STAGES-1:0]         vld_q, vld_d;
   logic [STAGES-1:0][CW-1:0] up_ctrl;
   logic [STAGES-1:0]         up_vld;
   logic [STAGES-1:0]         up_we;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      halt_q, halt_d;

   // Upstream source of each stage: decode for stage 0, previous latch otherwise.
   genvar g;
   for (g = 0; g < STAGES; g++) begin : g_up
      if (g == 0) begin : g_head
         assign up_ctrl[g] = valid_in ? ctrl_in : BUBBLE_CW;
         assign up_vld[g]  = valid_in;
         assign up_we[g]   = 1'b1;
      end else begin : g_body
         assign up_ctrl[g] = ctrl_q[g-1];
         assign up_vld[g]  = vld_q[g-1];
         assign up_we[g]   = write_en[g-1];
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      vld_d  = vld_q;
      for (int i = 0; i < STAGES; i++) begin
         if (flush[i]) begin
            ctrl_d[i] = BUBBLE_CW;
            vld_d[i]  = 1'b0;
         end else if (write_en[i]) begin
            // A stalled upstream stage keeps its entry, so feed a bubble to avoid duplication.
            ctrl_d[i] = up_we[i] ? up_ctrl[i] : BUBBLE_CW;
            vld_d[i]  = up_we[i] & up_vld[i];
         end
      end
   end

   assign retire = vld_q[STAGES-1] & write_en[STAGES-1] & ~flush[STAGES-1] & ~halt_q;

   always_comb begin
      cnt_d  = cnt_q;
      halt_d = halt_q;
      if (retire) begin
         if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
         if (ctrl_q[STAGES-1][HALT_BIT]) halt_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q <= {STAGES{BUBBLE_CW}};
         vld_q  <= '0;
         cnt_q  <= '0;
         halt_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
         halt_q <= halt_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d, bub_q, bub_d;
   logic             last_adv_bub;

   assign last_adv_bub = write_en[STAGES-1] & ~flush[STAGES-1] & ~vld_q[STAGES-1];

   always_comb begin
      stall_d = stall_q;
      bub_d   = bub_q;
      if (!halt_q && !write_en[0] && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
      if (!halt_q && last_adv_bub && !(&bub_q))   bub_d   = bub_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_q <= '0;
         bub_q   <= '0;
      end else begin
         stall_q <= stall_d;
         bub_q   <= bub_d;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bub_q;
`endif

   assign ctrl_stage  = ctrl_q;
   assign valid_stage = vld_q;
   assign num_inst    = cnt_q;
   assign is_halted   = halt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed self-checking bench for pipe_ctrl_chain (STAGES=3, CW=8, HALT_BIT=7).
module tb_pipe_ctrl_chain;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  ctrl_in;
   logic        valid_in;
   logic [2:0]  write_en;
   logic [2:0]  flush;
   logic [23:0] ctrl_stage;
   logic [2:0]  valid_stage;
   logic        retire;
   logic [15:0] num_inst;
   logic        is_halted;
`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_cnt;
   logic [15:0] bubble_cnt;
`endif

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   pipe_ctrl_chain #(
      .STAGES(3), .CW(8), .CNT_W(16), .HALT_BIT(7), .BUBBLE_CW(8'h00)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
      .write_en(write_en), .flush(flush), .ctrl_stage(ctrl_stage),
      .valid_stage(valid_stage), .retire(retire), .num_inst(num_inst),
`ifdef PIPE_CTRL_PERF_EN
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
      .is_halted(is_halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] c, input logic v, input logic [2:0] we, input logic [2:0] fl);
      ctrl_in  = c;
      valid_in = v;
      write_en = we;
      flush    = fl;
      #1;
   endtask

   function automatic logic [7:0] stg(input int k);
      return ctrl_stage[k*8 +: 8];
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      drive(8'hAA, 1'b1, 3'b111, 3'b000);
      tick(); tick();
      ntot++; if (valid_stage !== 3'b000) $display("FAIL reset_valid got=%b exp=000", valid_stage); else npass++;
      ntot++; if (ctrl_stage !== 24'h0) $display("FAIL reset_ctrl got=%h exp=000000", ctrl_stage); else npass++;
      ntot++; if (num_inst !== 16'd0 || is_halted !== 1'b0)
         $display("FAIL reset_cnt got=%0d/%b exp=0/0", num_inst, is_halted); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
      reset_n = 1'b1;
   endtask

   task automatic test_flow();
      drive(8'h11, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h12, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h13, 1'b1, 3'b111, 3'b000); tick();
      ntot++; if (stg(2) !== 8'h11 || valid_stage !== 3'b111)
         $display("FAIL flow_latency got=%h/%b exp=11/111", stg(2), valid_stage); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
      for (int i = 0; i < 3; i++) begin
         ntot++; if (retire !== 1'b1) $display("FAIL flow_retire%0d got=%b exp=1", i, retire); else npass++;
         tick();
      end
      ntot++; if (retire !== 1'b0) $display("FAIL flow_retire_end got=%b exp=0", retire); else npass++;
      ntot++; if (num_inst !== 16'd3) $display("FAIL flow_count got=%0d exp=3", num_inst); else npass++;
   endtask

   task automatic test_stall_bubble();
      drive(8'h21, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h22, 1'b1, 3'b110, 3'b000);
      for (int i = 0; i < 2; i++) begin
         tick();
         ntot++; if (valid_stage !== 3'b001 || stg(0) !== 8'h21)
            $display("FAIL stall_bubble%0d got=%b/%h exp=001/21", i, valid_stage, stg(0)); else npass++;
      end
      drive(8'h22, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h00, 1'b0, 3'b111, 3'b000); tick();
      ntot++; if (stg(2) !== 8'h21 || valid_stage[2] !== 1'b1 || retire !== 1'b1)
         $display("FAIL stall_s2 got=%h/%b/%b exp=21/1/1", stg(2), valid_stage[2], retire); else npass++;
      tick();
      ntot++; if (stg(2) !== 8'h22 || num_inst !== 16'd4)
         $display("FAIL stall_next got=%h/%0d exp=22/4", stg(2), num_inst); else npass++;
      tick(); tick();
      ntot++; if (valid_stage !== 3'b000 || num_inst !== 16'd5)
         $display("FAIL stall_count got=%b/%0d exp=000/5", valid_stage, num_inst); else npass++;
   endtask

   task automatic test_last_stall();
      drive(8'h33, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h00, 1'b0, 3'b111, 3'b000); tick(); tick();
      drive(8'h00, 1'b0, 3'b011, 3'b000);
      for (int i = 0; i < 3; i++) begin
         ntot++; if (retire !== 1'b0) $display("FAIL hold_retire%0d got=%b exp=0", i, retire); else npass++;
         tick();
      end
      ntot++; if (stg(2) !== 8'h33 || valid_stage[2] !== 1'b1 || num_inst !== 16'd5)
         $display("FAIL hold_state got=%h/%b/%0d exp=33/1/5", stg(2), valid_stage[2], num_inst); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
      ntot++; if (retire !== 1'b1) $display("FAIL hold_release got=%b exp=1", retire); else npass++;
      tick();
      ntot++; if (num_inst !== 16'd6 || retire !== 1'b0)
         $display("FAIL hold_once got=%0d/%b exp=6/0", num_inst, retire); else npass++;
   endtask

   task automatic test_flush();
      drive(8'h44, 1'b1, 3'b111, 3'b001); tick();
      ntot++; if (valid_stage[0] !== 1'b0 || stg(0) !== 8'h00)
         $display("FAIL flush_s0 got=%b/%h exp=0/00", valid_stage[0], stg(0)); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000); tick();
      ntot++; if (valid_stage[1] !== 1'b0) $display("FAIL flush_s1 got=%b exp=0", valid_stage[1]); else npass++;
      tick(); tick();
      ntot++; if (num_inst !== 16'd6) $display("FAIL flush_count got=%0d exp=6", num_inst); else npass++;
      drive(8'h55, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h00, 1'b0, 3'b111, 3'b000); tick(); tick();
      drive(8'h00, 1'b0, 3'b111, 3'b100);
      ntot++; if (retire !== 1'b0) $display("FAIL flush_last_retire got=%b exp=0", retire); else npass++;
      tick();
      ntot++; if (valid_stage[2] !== 1'b0 || num_inst !== 16'd6)
         $display("FAIL flush_last got=%b/%0d exp=0/6", valid_stage[2], num_inst); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
   endtask

   task automatic test_halt();
      drive(8'h85, 1'b1, 3'b111, 3'b000); tick();
      drive(8'h01, 1'b1, 3'b111, 3'b000); tick(); tick();
      ntot++; if (retire !== 1'b1 || is_halted !== 1'b0)
         $display("FAIL halt_pre got=%b/%b exp=1/0", retire, is_halted); else npass++;
      tick();
      ntot++; if (is_halted !== 1'b1 || num_inst !== 16'd7)
         $display("FAIL halt_set got=%b/%0d exp=1/7", is_halted, num_inst); else npass++;
      ntot++; if (retire !== 1'b0 || valid_stage[2] !== 1'b1)
         $display("FAIL halt_block got=%b/%b exp=0/1", retire, valid_stage[2]); else npass++;
      tick(); tick(); tick();
      ntot++; if (num_inst !== 16'd7 || is_halted !== 1'b1 || stg(2) !== 8'h01)
         $display("FAIL halt_frozen got=%0d/%b/%h exp=7/1/01", num_inst, is_halted, stg(2)); else npass++;
      reset_n = 1'b0; tick();
      ntot++; if (num_inst !== 16'd0 || is_halted !== 1'b0 || valid_stage !== 3'b000)
         $display("FAIL halt_reset got=%0d/%b/%b exp=0/0/000", num_inst, is_halted, valid_stage); else npass++;
      reset_n = 1'b1;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      drive(8'h00, 1'b0, 3'b110, 3'b000); tick(); tick();
      ntot++; if (stall_cnt !== 16'd2) $display("FAIL perf_stall got=%0d exp=2", stall_cnt); else npass++;
      ntot++; if (bubble_cnt !== 16'd2) $display("FAIL perf_bubble got=%0d exp=2", bubble_cnt); else npass++;
      drive(8'h00, 1'b0, 3'b111, 3'b000);
   endtask
`endif

   task automatic test_saturate();
      drive(8'h01, 1'b1, 3'b111, 3'b000);
      for (int i = 0; i < 65537; i++) tick();
      ntot++; if (num_inst !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", num_inst); else npass++;
      tick();
      ntot++; if (num_inst !== 16'hFFFF || retire !== 1'b1)
         $display("FAIL sat_full got=%h/%b exp=ffff/1", num_inst, retire); else npass++;
      tick();
      ntot++; if (num_inst !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", num_inst); else npass++;
   endtask

   initial begin
      test_reset();
      test_flow();
      test_stall_bubble();
      test_last_stall();
      test_flush();
      test_halt();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      test_saturate();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
